// File: rtl/tt_um_hoene_led_pwm_array_pkg.sv
// rtl/tt_um_hoene_led_pwm_array_pkg.sv - shared limits and phase-offset helper for the PWM array
package tt_um_hoene_led_pwm_array_pkg;

    localparam int NUM_CH_MIN = 1;
    localparam int NUM_CH_MAX = 8;
    localparam int WIDTH_MIN  = 4;
    localparam int WIDTH_MAX  = 12;

    // Spread the channel compare points evenly over one period so LED inrush is staggered.
    function automatic int phase_offset(input int ch, input int width, input int num_ch,
                                        input int stagger);
        if (stagger == 0) begin
            return 0;
        end
        return ch * ((1 << width) / num_ch);
    endfunction

endpackage

// File: rtl/tt_um_hoene_led_pwm_array_if.sv
// rtl/tt_um_hoene_led_pwm_array_if.sv - duty load / enable bus and PWM status outputs
interface tt_um_hoene_led_pwm_array_if #(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 10
);
    logic [NUM_CH*WIDTH-1:0] data;
    logic                    load;
    logic                    enable;
    logic [NUM_CH-1:0]       out;
    logic                    period_start;
    logic                    pending;

    modport master (
        output data, load, enable,
        input  out, period_start, pending
    );

    modport slave (
        input  data, load, enable,
        output out, period_start, pending
    );
endinterface

// File: rtl/tt_um_hoene_pwm_compare.sv
// rtl/tt_um_hoene_pwm_compare.sv - one PWM channel: phase add, duty compare, registered output
module tt_um_hoene_pwm_compare #(
    parameter int WIDTH  = 10,
    parameter int OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty,
    output logic             out
);
    localparam logic [WIDTH-1:0] PHASE_OFS = WIDTH'(OFFSET);
    localparam logic [WIDTH-1:0] DUTY_FULL = '1;

    logic [WIDTH-1:0] ph;

    // Modular add: the sum simply wraps at WIDTH bits.
    assign ph = cnt + PHASE_OFS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 1'b0;
        end else begin
            out <= enable && ((duty == DUTY_FULL) || (ph < duty));
        end
    end

endmodule

// File: rtl/tt_um_hoene_led_pwm_array.sv
// rtl/tt_um_hoene_led_pwm_array.sv - multi-channel LED PWM with shadowed duty update at period wrap
module tt_um_hoene_led_pwm_array
    import tt_um_hoene_led_pwm_array_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int WIDTH   = 10,
    parameter int STAGGER = 1
) (
    input logic                         clk,
    input logic                         rst_n,
    tt_um_hoene_led_pwm_array_if.slave  bus
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    generate
        if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX || WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_param
            $error("tt_um_hoene_led_pwm_array: NUM_CH or WIDTH out of range");
        end
    endgenerate

    logic [WIDTH-1:0]        cnt;
    logic [NUM_CH*WIDTH-1:0] shadow;
    logic [NUM_CH*WIDTH-1:0] active;
    logic                    pending;
    logic                    period_start;
    logic [NUM_CH-1:0]       out_w;
    logic                    wrap;
    logic                    apply_now;

    assign wrap      = bus.enable && (cnt == CNT_MAX);
    // While stopped nothing is being generated, so the shadow can be taken at once.
    assign apply_now = wrap || !bus.enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            shadow       <= '0;
            active       <= '0;
            pending      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= bus.enable ? cnt + 1'b1 : '0;
            period_start <= bus.enable && (cnt == '0);
            if (bus.load) begin
                shadow <= bus.data;
            end
            if (apply_now) begin
                active  <= bus.load ? bus.data : shadow;
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            tt_um_hoene_pwm_compare #(
                .WIDTH  (WIDTH),
                .OFFSET (phase_offset(g, WIDTH, NUM_CH, STAGGER))
            ) u_cmp (
                .clk    (clk),
                .rst_n  (rst_n),
                .enable (bus.enable),
                .cnt    (cnt),
                .duty   (active[g*WIDTH +: WIDTH]),
                .out    (out_w[g])
            );
        end
    endgenerate

    assign bus.out          = out_w;
    assign bus.pending      = pending;
    assign bus.period_start = period_start;

endmodule

// File: tb/tb_tt_um_hoene_led_pwm_array.sv
// tb/tb_tt_um_hoene_led_pwm_array.sv - directed bench for the LED PWM array (WIDTH=4, NUM_CH=3)
module tb_tt_um_hoene_led_pwm_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] data;
    logic        load;
    logic        enable;

    int errors = 0;
    int checks = 0;
    int cnt_m  = 0;

    int          hi [3];
    logic [15:0] mask_s [3];
    logic [15:0] mask_n [3];
    logic [15:0] ps_mask;
    logic        pend_seen;
    logic        any_out;
    logic        any_ps;

    always #5 clk = ~clk;

    tt_um_hoene_led_pwm_array_if #(.NUM_CH(3), .WIDTH(4)) if_s ();
    tt_um_hoene_led_pwm_array_if #(.NUM_CH(3), .WIDTH(4)) if_n ();

    assign if_s.data   = data;
    assign if_s.load   = load;
    assign if_s.enable = enable;
    assign if_n.data   = data;
    assign if_n.load   = load;
    assign if_n.enable = enable;

    tt_um_hoene_led_pwm_array #(.NUM_CH(3), .WIDTH(4), .STAGGER(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s)
    );

    tt_um_hoene_led_pwm_array #(.NUM_CH(3), .WIDTH(4), .STAGGER(0)) dut_nostag (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // cnt_m tracks the counter value present after the edge just taken.
    task automatic tick();
        if (!rst_n) cnt_m = 0;
        else        cnt_m = enable ? ((cnt_m + 1) & 15) : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int v);
        for (int k = 0; k < 40; k++) begin
            if (cnt_m == v) break;
            tick();
        end
    endtask

    // Starts with the counter at 0: sample j reflects counter value j.
    task automatic measure();
        for (int c = 0; c < 3; c++) begin
            hi[c] = 0; mask_s[c] = '0; mask_n[c] = '0;
        end
        ps_mask   = '0;
        pend_seen = 1'b0;
        for (int j = 0; j < 16; j++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                if (if_s.out[c]) begin
                    hi[c]++;
                    mask_s[c][j] = 1'b1;
                end
                if (if_n.out[c]) mask_n[c][j] = 1'b1;
            end
            ps_mask[j] = if_s.period_start;
            pend_seen  = pend_seen | if_s.pending;
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(if_s.out), 32'h0);
        check("reset_pending", 32'(if_s.pending), 32'h0);
        check("reset_period_start", 32'(if_s.period_start), 32'h0);

        // basic duties {ch2=15, ch1=0, ch0=4}
        rst_n = 1'b1; enable = 1'b1; load = 1'b1; data = {4'd15, 4'd0, 4'd4};
        cnt_m = 0;
        tick();
        load = 1'b0;
        check("first_pending", 32'(if_s.pending), 32'h1);
        check("first_period_start", 32'(if_s.period_start), 32'h1);
        wait_cnt(15);
        check("pending_before_wrap", 32'(if_s.pending), 32'h1);
        tick();
        check("pending_after_wrap", 32'(if_s.pending), 32'h0);
        measure();
        check("basic_ch0_high", 32'(hi[0]), 32'd4);
        check("basic_ch1_high", 32'(hi[1]), 32'd0);
        check("basic_ch2_high", 32'(hi[2]), 32'd16);
        check("basic_ch0_mask", 32'(mask_s[0]), 32'h000F);
        check("basic_period_start", 32'(ps_mask), 32'h0001);

        // stagger with all duties = 8
        data = {4'd8, 4'd8, 4'd8}; load = 1'b1;
        tick();
        load = 1'b0;
        wait_cnt(0);
        measure();
        check("stag_ch0_mask", 32'(mask_s[0]), 32'h00FF);
        check("stag_ch1_mask", 32'(mask_s[1]), 32'hF807);
        check("stag_ch2_mask", 32'(mask_s[2]), 32'h3FC0);
        check("nostag_ch0_mask", 32'(mask_n[0]), 32'h00FF);
        check("nostag_ch1_mask", 32'(mask_n[1]), 32'h00FF);
        check("nostag_ch2_mask", 32'(mask_n[2]), 32'h00FF);

        // two loads in one period: last wins
        wait_cnt(5);
        data = {4'd8, 4'd8, 4'd2}; load = 1'b1;
        tick();
        load = 1'b0;
        check("multi_pending_cnt6", 32'(if_s.pending), 32'h1);
        wait_cnt(9);
        check("multi_pending_cnt9", 32'(if_s.pending), 32'h1);
        data = {4'd8, 4'd8, 4'd6}; load = 1'b1;
        tick();
        load = 1'b0;
        wait_cnt(15);
        check("multi_pending_cnt15", 32'(if_s.pending), 32'h1);
        tick();
        check("multi_pending_wrap", 32'(if_s.pending), 32'h0);
        measure();
        check("multi_ch0_high", 32'(hi[0]), 32'd6);
        check("multi_ch1_high", 32'(hi[1]), 32'd8);

        // load exactly at wrap: bypass
        wait_cnt(15);
        data = {4'd8, 4'd8, 4'd3}; load = 1'b1;
        tick();
        load = 1'b0;
        check("bypass_pending", 32'(if_s.pending), 32'h0);
        measure();
        check("bypass_ch0_high", 32'(hi[0]), 32'd3);
        check("bypass_pend_seen", 32'(pend_seen), 32'h0);

        // disable for 7 cycles with a pending load
        wait_cnt(4);
        data = {4'd8, 4'd8, 4'd9}; load = 1'b1;
        tick();
        load = 1'b0;
        check("dis_pending_before", 32'(if_s.pending), 32'h1);
        enable = 1'b0;
        tick();
        check("dis_out", 32'(if_s.out), 32'h0);
        check("dis_pending", 32'(if_s.pending), 32'h0);
        check("dis_period_start", 32'(if_s.period_start), 32'h0);
        any_out = 1'b0; any_ps = 1'b0;
        repeat (6) begin
            tick();
            any_out = any_out | (|if_s.out);
            any_ps  = any_ps | if_s.period_start;
        end
        check("dis_out_held", 32'(any_out), 32'h0);
        check("dis_ps_held", 32'(any_ps), 32'h0);
        enable = 1'b1;
        measure();
        check("reen_ch0_high", 32'(hi[0]), 32'd9);
        check("reen_ch2_high", 32'(hi[2]), 32'd8);
        check("reen_period_start", 32'(ps_mask), 32'h0001);

        // asynchronous reset mid-period with pending data
        wait_cnt(10);
        data = {4'd8, 4'd8, 4'd5}; load = 1'b1;
        tick();
        load = 1'b0;
        check("rst_pending_before", 32'(if_s.pending), 32'h1);
        check("rst_out_before", 32'(if_s.out), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(if_s.out), 32'h0);
        check("async_rst_pending", 32'(if_s.pending), 32'h0);
        check("async_rst_ps", 32'(if_s.period_start), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        measure();
        check("post_rst_ch0_high", 32'(hi[0]), 32'd0);
        check("post_rst_ch1_high", 32'(hi[1]), 32'd0);
        check("post_rst_ch2_high", 32'(hi[2]), 32'd0);
        check("post_rst_period_start", 32'(ps_mask), 32'h0001);
        check("post_rst_pend_seen", 32'(pend_seen), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
